present_key_expander: RTL

Sequential PRESENT round-key generator that sits directly upstream of the encryption core. On a start pulse it expands the cipher key into all 32 64-bit round keys, one per clock, and stores them in an internal key file. The encryption core reads the round key for its current round through a registered read port. This replaces the per-round combinational key fan-out with one shared iterative schedule.

---
 rtl/present_pkg.sv | 50 +++++
 rtl/present_key_round.sv | 39 +++
 rtl/present_key_expander.sv | 107 ++++++++++
 3 files changed

// File: rtl/present_pkg.sv
// ============================================================================
// Module      : present_pkg
// Description : Shared PRESENT key-schedule constants, state type and S-box.
//               Define PRESENT_KEY128_EN to build for 128-bit cipher keys.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package present_pkg;

    localparam int NUM_KEYS = 32;
    localparam int RK_WIDTH = 64;
`ifdef PRESENT_KEY128_EN
    localparam int KEY_WIDTH = 128;
`else
    localparam int KEY_WIDTH = 80;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_e;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

endpackage

`default_nettype wire

// File: rtl/present_key_round.sv
// ============================================================================
// Module      : present_key_round
// Description : One combinational PRESENT key-schedule step (80- or 128-bit,
//               selected by PRESENT_KEY128_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module present_key_round
    import present_pkg::*;
(
    input  logic [KEY_WIDTH-1:0] key_in,
    input  logic [4:0]           round_ctr,
    output logic [KEY_WIDTH-1:0] key_out
);

    logic [KEY_WIDTH-1:0] w_rot;

    always_comb begin
        key_out = '0;
`ifdef PRESENT_KEY128_EN
        // rotate left by 61 == rotate right by 67
        w_rot            = {key_in[66:0], key_in[127:67]};
        key_out          = w_rot;
        key_out[127:124] = sbox(w_rot[127:124]);
        key_out[123:120] = sbox(w_rot[123:120]);
        key_out[66:62]   = w_rot[66:62] ^ round_ctr;
`else
        // rotate left by 61 == rotate right by 19
        w_rot          = {key_in[18:0], key_in[79:19]};
        key_out        = w_rot;
        key_out[79:76] = sbox(w_rot[79:76]);
        key_out[19:15] = w_rot[19:15] ^ round_ctr;
`endif
    end

endmodule

`default_nettype wire

// File: rtl/present_key_expander.sv
// ============================================================================
// Module      : present_key_expander
// Description : Iterative PRESENT round-key generator with a 32-entry key file
//               and registered read port. PRESENT_KEY128_EN selects 128-bit keys.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module present_key_expander
    import present_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [KEY_WIDTH-1:0] orig_key,
    input  logic [4:0]           rd_idx,
    output logic [RK_WIDTH-1:0]  round_key,
    output logic                 Busy,
    output logic                 Ready
);

    localparam logic [4:0] c_LAST_ROUND = 5'd31;

    state_e               r_state;
    state_e               w_state_next;
    logic                 w_accept;
    logic                 w_advance;
    logic [4:0]           r_round;
    logic [KEY_WIDTH-1:0] r_key;
    logic [KEY_WIDTH-1:0] w_key_next;
    logic [RK_WIDTH-1:0]  r_key_file [NUM_KEYS];

    present_key_round u_round (
        .key_in    (r_key),
        .round_ctr (r_round),
        .key_out   (w_key_next)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            IDLE, READY: begin
                if (Start) begin
                    w_accept     = 1'b1;
                    w_state_next = EXPAND;
                end
            end
            EXPAND: begin
                w_advance = 1'b1;
                if (r_round == c_LAST_ROUND) begin
                    w_state_next = READY;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_round <= '0;
            r_key   <= '0;
        end else if (w_accept) begin
            r_round <= 5'd1;
            r_key   <= orig_key;
        end else if (w_advance) begin
            r_key <= w_key_next;
            if (r_round != c_LAST_ROUND) begin
                r_round <= r_round + 5'd1;
            end
        end
    end

    // Key file is storage only; contents are qualified by Ready.
    always_ff @(posedge Clock) begin
        if (w_accept) begin
            r_key_file[0] <= orig_key[KEY_WIDTH-1 -: RK_WIDTH];
        end else if (w_advance) begin
            r_key_file[r_round] <= w_key_next[KEY_WIDTH-1 -: RK_WIDTH];
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            round_key <= '0;
        end else if (r_state == READY) begin
            round_key <= r_key_file[rd_idx];
        end else begin
            round_key <= '0;
        end
    end

    assign Busy  = (r_state == EXPAND);
    assign Ready = (r_state == READY);

endmodule

`default_nettype wire
